// File: rtl/proc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-ack timeout.
// Define PROC_SEQ_PERF_EN to add the retired/cycles performance counters.
module proc_seq_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             WRITE_MF,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  input  logic             br_taken,
  output logic [3:0]       state,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_imm,
  output logic             instruction_executed,
  output logic             halted,
  output logic             fault
`ifdef PROC_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_FETCH  = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_HALT   = 4'd7,
    S_FAULT  = 4'd8
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic is_r, is_lw, is_sw, is_beq, is_j, is_halt;
  logic waiting;
  logic mem_req_int, mem_we_int, ir_we_int, pc_we_int;
  logic reg_we_int, reg_dst_int, mem_to_reg_int, alu_src_imm_int, retire_int;
  logic [1:0] pc_src_int;

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_halt = (opcode == OP_HALT);

  always_comb begin
    state_d         = state_q;
    wait_d          = '0;
    waiting         = 1'b0;
    mem_req_int     = 1'b0;
    mem_we_int      = 1'b0;
    ir_we_int       = 1'b0;
    pc_we_int       = 1'b0;
    pc_src_int      = 2'b00;
    reg_we_int      = 1'b0;
    reg_dst_int     = 1'b0;
    mem_to_reg_int  = 1'b0;
    alu_src_imm_int = 1'b0;
    retire_int      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (WRITE_MF)  state_d = S_LOAD;
        else if (run)  state_d = S_FETCH;
      end
      S_LOAD: begin
        if (!WRITE_MF) state_d = S_IDLE;
      end
      S_FETCH: begin
        mem_req_int = 1'b1;
        if (mem_ack) begin
          ir_we_int = 1'b1;
          pc_we_int = 1'b1;
          state_d   = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw) begin
          alu_src_imm_int = 1'b1;
          state_d         = S_MEM;
        end else if (is_beq) begin
          pc_we_int  = br_taken;
          pc_src_int = 2'b01;
          retire_int = 1'b1;
          state_d    = S_FETCH;
        end else if (is_j) begin
          pc_we_int  = 1'b1;
          pc_src_int = 2'b10;
          retire_int = 1'b1;
          state_d    = S_FETCH;
        end else if (is_halt) begin
          retire_int = 1'b1;
          state_d    = S_HALT;
        end else begin
          alu_src_imm_int = !is_r;
          state_d         = S_WB;
        end
      end
      S_MEM: begin
        mem_req_int = 1'b1;
        mem_we_int  = is_sw;
        if (mem_ack) begin
          if (is_sw) begin
            retire_int = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        reg_we_int     = 1'b1;
        reg_dst_int    = is_r;
        mem_to_reg_int = is_lw;
        retire_int     = 1'b1;
        state_d        = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Any cycle not spent waiting leaves the counter at zero, so entry clears it.
    if (waiting) begin
      wait_d = wait_q + 8'd1;
      if (wait_d >= TIMEOUT_C) state_d = S_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are forced low for as long as reset is held, even mid-instruction.
  assign state                = rst_n ? 4'(state_q) : 4'd0;
  assign mem_req              = rst_n & mem_req_int;
  assign mem_we               = rst_n & mem_we_int;
  assign ir_we                = rst_n & ir_we_int;
  assign pc_we                = rst_n & pc_we_int;
  assign pc_src               = rst_n ? pc_src_int : 2'b00;
  assign reg_we               = rst_n & reg_we_int;
  assign reg_dst              = rst_n & reg_dst_int;
  assign mem_to_reg           = rst_n & mem_to_reg_int;
  assign alu_src_imm          = rst_n & alu_src_imm_int;
  assign instruction_executed = rst_n & retire_int;
  assign halted               = rst_n & (state_q == S_HALT);
  assign fault                = rst_n & (state_q == S_FAULT);

`ifdef PROC_SEQ_PERF_EN
  logic [CNT_W-1:0] retired_q, retired_d, cycles_q, cycles_d;
  logic             active;

  assign active = (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});

  always_comb begin
    retired_d = retired_q + CNT_W'(retire_int);
    cycles_d  = cycles_q + CNT_W'(active);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  assign retired = rst_n ? retired_q : '0;
  assign cycles  = rst_n ? cycles_q : '0;
`endif

endmodule

// File: doc/proc_seq_ctrl.md
# proc_seq_ctrl

Multi-cycle control sequencer for the 32-register processor datapath. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, issues all datapath write strobes and memory requests, and pulses `instruction_executed` once per retired instruction. Also gates memory-file loading (`WRITE_MF`), enforces a memory-ack timeout, and optionally keeps performance counters.

## Interface
- `TIMEOUT`, default 15: memory wait cycles without `mem_ack` before fault; legal range 1..255.
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `WRITE_MF`  in  1  memory-file load request; honoured only from IDLE
- `run`  in  1  start execution, level-sampled in IDLE
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `mem_ack`  in  1  memory completes the current request this cycle
- `br_taken`  in  1  ALU zero flag, valid in EXEC
- `state`  out  4  current state encoding
- `mem_req`  out  1  memory request
- `mem_we`  out  1  store qualifier for `mem_req`
- `ir_we`  out  1  IR load strobe
- `pc_we`  out  1  PC load strobe
- `pc_src`  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target
- `reg_we`  out  1  register-file write strobe
- `reg_dst`  out  1  write destination: 1 = rd, 0 = rt
- `mem_to_reg`  out  1  writeback data from memory
- `alu_src_imm`  out  1  ALU operand B is the immediate
- `instruction_executed`  out  1  one-cycle retire pulse
- `halted`  out  1  high in HALT
- `fault`  out  1  high in FAULT
- `retired`  out  CNT_W  retired-instruction count (macro only)
- `cycles`  out  CNT_W  count of cycles spent outside IDLE/LOAD/HALT/FAULT (macro only)

## Operation
- State encodings: IDLE=0, LOAD=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7, FAULT=8.
- Opcode decode:
  - 00 → R-type
  - 23 → lw
  - 2B → sw
  - 04 → beq
  - 02 → j
  - 3F → halt
  - any other → I-type ALU
- IDLE:
  - `WRITE_MF`=1 → LOAD. This has priority over `run`.
  - `run`=1 → FETCH.
- LOAD → IDLE when `WRITE_MF` falls. `WRITE_MF` is ignored in every other state.
- FETCH:
  - `mem_req`=1, `mem_we`=0.
  - On `mem_ack`: `ir_we`=1, `pc_we`=1, `pc_src`=00, next state DECODE.
- DECODE: one cycle, no strobes, next state EXEC.
- EXEC:
  - R-type / I-type → WB. `alu_src_imm`=1 for I-type.
  - lw / sw → MEM with `alu_src_imm`=1.
  - beq → FETCH with `pc_we`=`br_taken`, `pc_src`=01, retire.
  - j → FETCH with `pc_we`=1, `pc_src`=10, retire.
  - halt → HALT, retire.
- MEM:
  - `mem_req`=1. `mem_we`=1 for sw.
  - On `mem_ack`: sw retires and goes to FETCH; lw goes to WB.
- WB:
  - `reg_we`=1.
  - `reg_dst`=1 for R-type only.
  - `mem_to_reg`=1 for lw only.
  - Retire, next state FETCH.
- HALT and FAULT are sticky until `rst_n`=0.
- Timeout: an 8-bit wait counter clears on entry to FETCH or MEM and increments on each cycle without `mem_ack`. When it reaches `TIMEOUT` → FAULT. If `mem_ack` arrives on that same cycle, the ack wins.

## Timing
- All strobes are combinational from state and the current inputs, valid in the same cycle. `instruction_executed` is combinational as well and asserts on the retiring cycle only.
- Latency with `mem_ack` the first cycle of each request:
  - R-type / I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq / j / halt: 3 cycles
- Each memory wait cycle adds one cycle of latency.
- Reset:
  - `rst_n`=0 at a rising edge → IDLE, all counters 0.
  - While `rst_n`=0 every output is 0, including mid-instruction; the in-flight instruction is dropped without retiring.
- `run` held high after retire has no effect; sequencing continues automatically until halt or fault.

## Configuration
- `PROC_SEQ_PERF_EN` defined:
  - `retired` increments on each `instruction_executed`.
  - `cycles` increments in states 2..6.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Not defined: the `retired` and `cycles` ports and their logic are absent.

## Test plan
- Reset mid-lw (state=MEM, `rst_n`=0 for 1 cycle) → `state`=0, all outputs 0, no `instruction_executed` pulse.
- `run`=1 with immediate acks, opcodes 00, 23, 2B, 04 (`br_taken`=1), 02, 3F → retire pulses at cycles 4, 9, 13, 16, 19, 22. With `PROC_SEQ_PERF_EN`: `retired`=6; `cycles`=21 at retire 6 and 22 thereafter. Then `halted`=1.
- beq with `br_taken`=0 → `pc_we`=0 in EXEC, `pc_src`=01, retire pulse still 1.
- `WRITE_MF`=1 and `run`=1 together in IDLE → LOAD; `run` is ignored until `WRITE_MF`=0. Then IDLE, then FETCH on the next `run`.
- FETCH with no `mem_ack`, `TIMEOUT`=15 → `fault`=1 after 15 cycles, sticky. Repeat with ack on the 15th cycle → DECODE, no fault.
- sw with 3 wait cycles in MEM → `mem_we`=1 for 4 cycles; retire coincides with `mem_ack`, no `reg_we`.
